// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared widths, reset vector default and fetch FSM encoding
package instruction_fetch_pkg;

  localparam int          XLEN                 = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR              = 32'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_MISS = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - cache lookup, redirect and decode-slot signals of the fetch stage
interface instruction_fetch_if #(
  parameter int CNT_WIDTH = 32
);
  import instruction_fetch_pkg::*;

  logic                 fetch_enable;
  logic [XLEN-1:0]      icache_address;
  logic                 icache_miss;
  logic [XLEN-1:0]      icache_data;
  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_target;
  logic [XLEN-1:0]      instr;
  logic [XLEN-1:0]      instr_pc;
  logic                 instr_valid;
  logic                 decode_ready;
  logic                 fetch_misaligned;
  logic                 miss_stall;
  logic [CNT_WIDTH-1:0] miss_events;
  logic [CNT_WIDTH-1:0] miss_cycles;

  modport master (
    input  fetch_enable, icache_miss, icache_data, redirect_valid, redirect_target, decode_ready,
    output icache_address, instr, instr_pc, instr_valid, fetch_misaligned, miss_stall,
           miss_events, miss_cycles
  );

  modport slave (
    output fetch_enable, icache_miss, icache_data, redirect_valid, redirect_target, decode_ready,
    input  icache_address, instr, instr_pc, instr_valid, fetch_misaligned, miss_stall,
           miss_events, miss_cycles
  );

endinterface

// File: rtl/instruction_fetch_saturating_counter.sv
// rtl/instruction_fetch_saturating_counter.sv - up counter that sticks at all-ones
module saturating_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC register, single-entry decode slot, miss stall FSM and miss statistics
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          CNT_WIDTH    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  instruction_fetch_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic            misaligned_q, misaligned_d;
  logic            slot_free;
  logic            consume;
  logic            events_inc;
  logic            cycles_inc;

  assign slot_free = !instr_valid_q || bus.decode_ready;
  assign consume   = instr_valid_q && bus.decode_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    misaligned_d  = 1'b0;
    // Redirect wins over everything and flushes the slot even if decode takes it this cycle.
    if (bus.redirect_valid) begin
      pc_d          = {bus.redirect_target[XLEN-1:2], 2'b00};
      instr_valid_d = 1'b0;
      state_d       = ST_RUN;
      misaligned_d  = (bus.redirect_target[1:0] != 2'b00);
    end else if (bus.fetch_enable && !bus.icache_miss && slot_free) begin
      instr_d       = bus.icache_data;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
      pc_d          = pc_q + PC_INCR;
      state_d       = ST_RUN;
    end else if (bus.fetch_enable && bus.icache_miss) begin
      state_d = ST_MISS;
      if (consume) instr_valid_d = 1'b0;
    end else begin
      // A hit blocked by back-pressure or a disabled fetch still ends a miss.
      if (!bus.icache_miss) state_d = ST_RUN;
      if (consume) instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_VECTOR;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign events_inc = (state_q == ST_RUN) && (state_d == ST_MISS);
  assign cycles_inc = (state_q == ST_MISS);

  saturating_counter #(.WIDTH(CNT_WIDTH)) u_miss_events (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (events_inc),
    .count   (bus.miss_events)
  );

  saturating_counter #(.WIDTH(CNT_WIDTH)) u_miss_cycles (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (cycles_inc),
    .count   (bus.miss_cycles)
  );

  assign bus.icache_address   = pc_q;
  assign bus.instr            = instr_q;
  assign bus.instr_pc         = instr_pc_q;
  assign bus.instr_valid      = instr_valid_q;
  assign bus.fetch_misaligned = misaligned_q;
  assign bus.miss_stall       = (state_q == ST_MISS);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed vector table, corner sequences and randomized model check
module tb_instruction_fetch;

  localparam int          CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;
  localparam logic [31:0] RV   = 32'h0000_0100;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  instruction_fetch_if #(.CNT_WIDTH(CW)) ifc ();

  instruction_fetch #(.RESET_VECTOR(RV), .CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.master)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign ifc.icache_data = word_of(ifc.icache_address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fe, miss, dr, rv;
    logic [31:0] rt;
    logic [31:0] e_addr, e_ipc;
    logic        e_valid, e_stall, e_mis;
    int          e_ev, e_cy;
  } vec_t;

  vec_t tbl[$];

  logic [31:0] m_pc, m_instr, m_ipc;
  bit          m_valid, m_miss, m_mis;
  int          m_ev, m_cy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic fe, miss, dr, rv, input logic [31:0] rt,
                     input logic [31:0] ea, ei, input logic ev_, es, em, input int eev, ecy);
    vec_t v;
    v.fe = fe; v.miss = miss; v.dr = dr; v.rv = rv; v.rt = rt;
    v.e_addr = ea; v.e_ipc = ei; v.e_valid = ev_; v.e_stall = es; v.e_mis = em;
    v.e_ev = eev; v.e_cy = ecy;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic fe, miss, dr, rv, input logic [31:0] rt);
    ifc.fetch_enable    = fe;
    ifc.icache_miss     = miss;
    ifc.decode_ready    = dr;
    ifc.redirect_valid  = rv;
    ifc.redirect_target = rt;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".addr"},  ifc.icache_address, RV);
    chk({tag, ".valid"}, 32'(ifc.instr_valid), 32'd0);
    chk({tag, ".instr"}, ifc.instr, 32'd0);
    chk({tag, ".ipc"},   ifc.instr_pc, 32'd0);
    chk({tag, ".stall"}, 32'(ifc.miss_stall), 32'd0);
    chk({tag, ".mis"},   32'(ifc.fetch_misaligned), 32'd0);
    chk({tag, ".ev"},    32'(ifc.miss_events), 32'd0);
    chk({tag, ".cy"},    32'(ifc.miss_cycles), 32'd0);
  endtask

  task automatic model_reset();
    m_pc = RV; m_instr = 0; m_ipc = 0;
    m_valid = 0; m_miss = 0; m_mis = 0; m_ev = 0; m_cy = 0;
  endtask

  task automatic model_step(input logic fe, miss, dr, rv, input logic [31:0] rt);
    bit was_miss, next_miss, take;
    was_miss  = m_miss;
    next_miss = was_miss;
    take      = m_valid && dr;
    m_mis     = 0;
    if (rv) begin
      m_pc = rt - (rt % 4);
      m_valid = 0;
      next_miss = 0;
      m_mis = (rt % 4) != 0;
    end else if (fe && !miss && (!m_valid || dr)) begin
      m_instr = word_of(m_pc);
      m_ipc = m_pc;
      m_valid = 1;
      m_pc = m_pc + 4;
      next_miss = 0;
    end else begin
      if (take) m_valid = 0;
      if (fe && miss) next_miss = 1;
      else if (!miss) next_miss = 0;
    end
    if (!was_miss && next_miss && m_ev < CMAX) m_ev++;
    if (was_miss && m_cy < CMAX) m_cy++;
    m_miss = next_miss;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".addr"},  ifc.icache_address, m_pc);
    chk({tag, ".valid"}, 32'(ifc.instr_valid), 32'(m_valid));
    chk({tag, ".ipc"},   ifc.instr_pc, m_ipc);
    chk({tag, ".instr"}, ifc.instr, m_instr);
    chk({tag, ".stall"}, 32'(ifc.miss_stall), 32'(m_miss));
    chk({tag, ".mis"},   32'(ifc.fetch_misaligned), 32'(m_mis));
    chk({tag, ".ev"},    32'(ifc.miss_events), 32'(m_ev));
    chk({tag, ".cy"},    32'(ifc.miss_cycles), 32'(m_cy));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 32'd0);

    //   fe miss dr rv target        addr          ipc           v  st mis ev cy
    add(1, 0, 1, 0, 32'h0,   32'h104, 32'h100, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,   32'h108, 32'h104, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 32'h0,   32'h108, 32'h104, 0, 1, 0, 1, 0);
    add(1, 1, 1, 0, 32'h0,   32'h108, 32'h104, 0, 1, 0, 1, 1);
    add(1, 1, 1, 0, 32'h0,   32'h108, 32'h104, 0, 1, 0, 1, 2);
    add(1, 0, 1, 0, 32'h0,   32'h10C, 32'h108, 1, 0, 0, 1, 3);
    add(1, 0, 0, 0, 32'h0,   32'h10C, 32'h108, 1, 0, 0, 1, 3);
    add(1, 0, 0, 0, 32'h0,   32'h10C, 32'h108, 1, 0, 0, 1, 3);
    add(1, 0, 1, 0, 32'h0,   32'h110, 32'h10C, 1, 0, 0, 1, 3);
    add(1, 1, 1, 0, 32'h0,   32'h110, 32'h10C, 0, 1, 0, 2, 3);
    add(1, 1, 1, 1, 32'h200, 32'h200, 32'h10C, 0, 0, 0, 2, 4);
    add(1, 0, 1, 0, 32'h0,   32'h204, 32'h200, 1, 0, 0, 2, 4);
    add(1, 0, 1, 1, 32'h303, 32'h300, 32'h200, 0, 0, 1, 2, 4);
    add(1, 0, 1, 0, 32'h0,   32'h304, 32'h300, 1, 0, 0, 2, 4);
    add(0, 0, 1, 0, 32'h0,   32'h304, 32'h300, 0, 0, 0, 2, 4);
    add(0, 1, 0, 0, 32'h0,   32'h304, 32'h300, 0, 0, 0, 2, 4);

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].fe, tbl[i].miss, tbl[i].dr, tbl[i].rv, tbl[i].rt);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d.addr", i),  ifc.icache_address, tbl[i].e_addr);
      chk($sformatf("vec%0d.ipc", i),   ifc.instr_pc, tbl[i].e_ipc);
      chk($sformatf("vec%0d.instr", i), ifc.instr, word_of(tbl[i].e_ipc));
      chk($sformatf("vec%0d.valid", i), 32'(ifc.instr_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d.stall", i), 32'(ifc.miss_stall), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d.mis", i),   32'(ifc.fetch_misaligned), 32'(tbl[i].e_mis));
      chk($sformatf("vec%0d.ev", i),    32'(ifc.miss_events), 32'(tbl[i].e_ev));
      chk($sformatf("vec%0d.cy", i),    32'(ifc.miss_cycles), 32'(tbl[i].e_cy));
    end

    // Long miss: cycle counter must stick at 15 rather than wrap.
    drive(1, 1, 1, 0, 32'd0);
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("sat.cy",    32'(ifc.miss_cycles), 32'd15);
    chk("sat.ev",    32'(ifc.miss_events), 32'd3);
    chk("sat.stall", 32'(ifc.miss_stall), 32'd1);
    chk("sat.addr",  ifc.icache_address, 32'h304);

    // Reset asserted mid-miss, checked before any clock edge.
    reset_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    for (int n = 0; n < 400; n++) begin
      logic fe, miss, dr, rv;
      logic [31:0] rt;
      fe   = ($urandom_range(0, 99) < 85);
      miss = ($urandom_range(0, 99) < 30);
      dr   = ($urandom_range(0, 99) < 70);
      rv   = ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 3))
        0:       rt = 32'hFFFF_FFF4 + 32'($urandom_range(0, 11));
        default: rt = $urandom;
      endcase
      drive(fe, miss, dr, rv, rt);
      @(posedge clk);
      model_step(fe, miss, dr, rv, rt);
      @(negedge clk);
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage sitting directly upstream of the L1 instruction cache. Holds the program counter, drives the cache lookup address, captures the returned word on a hit into a registered output slot for decode, stalls while the cache reports a miss, and accepts redirects from the execute stage. Also keeps saturating miss statistics for performance analysis.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- CNT_WIDTH, 32, width of the miss statistics counters
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_enable  in  1  when low no new fetch is launched; PC and output slot hold except for decode consumption
- icache_address  out  32  lookup address to the instruction cache, equals PC register
- icache_miss  in  1  cache miss for icache_address, combinational in the same cycle
- icache_data  in  32  instruction word for icache_address, valid when icache_miss=0
- redirect_valid  in  1  branch/jump taken, flush and restart
- redirect_target  in  32  new PC
- instr  out  32  fetched instruction
- instr_pc  out  32  address of instr
- instr_valid  out  1  output slot holds an instruction
- decode_ready  in  1  decode consumes the slot this cycle when instr_valid=1
- fetch_misaligned  out  1  one-cycle pulse: redirect_target[1:0] != 0
- miss_stall  out  1  FSM is in MISS
- miss_events  out  CNT_WIDTH  number of RUN->MISS transitions, saturating
- miss_cycles  out  CNT_WIDTH  cycles spent in MISS, saturating

## Operation
- Reset (async, reset_n=0): pc=RESET_VECTOR, state=RUN, instr=0, instr_pc=0, instr_valid=0, fetch_misaligned=0, both counters 0; icache_address=RESET_VECTOR, miss_stall=0.
- slot_free = !instr_valid || decode_ready.
- Priority per cycle, highest first:
- 1. redirect_valid: pc <= {redirect_target[31:2],2'b00}; instr_valid <= 0 (in-flight slot flushed even if decode_ready); state <= RUN; fetch_misaligned <= (redirect_target[1:0]!=0). No capture this cycle.
- 2. fetch_enable && !icache_miss && slot_free: instr <= icache_data, instr_pc <= pc, instr_valid <= 1, pc <= pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); state <= RUN.
- 3. fetch_enable && icache_miss: state <= MISS; pc held; if instr_valid && decode_ready then instr_valid <= 0.
- 4. otherwise: pc held; if instr_valid && decode_ready then instr_valid <= 0.
- FSM: RUN -> MISS on case 3; MISS -> RUN when icache_miss=0 (case 2 or 4) or on redirect. MISS -> MISS while icache_miss=1.
- miss_events += 1 on each RUN->MISS transition; miss_cycles += 1 every cycle state==MISS. Both saturate at all-ones, never wrap.
- fetch_misaligned is 0 in every cycle without a redirect.

## Timing
- icache_address is a direct wire from pc register; cache lookup is combinational, so hit is resolved in the same cycle.
- Latency: PC presented in cycle N with hit -> instr_valid=1, instr/instr_pc updated after edge N (visible N+1).
- Throughput: one instruction per cycle with continuous hits and decode_ready=1.
- Back-pressure: instr_valid=1 and decode_ready=0 -> slot, pc held, no capture, even on hit.
- Redirect and decode_ready same cycle: slot dropped, not handed over as new data; first instruction from target appears two edges after redirect (one edge to load pc, one to capture).
- Redirect during MISS: miss abandoned immediately, no extra count for that cycle's transition.
- Reset mid-miss or mid-stall: all state returns to reset values asynchronously.

## Structure
- Shared package: instruction/address width (32), RESET_VECTOR default, FSM state encodings (RUN, MISS), PC increment constant 4.
- Sub-module: saturating_counter (parameter WIDTH; inputs clk, reset_n, inc; output count), instantiated twice for miss_events and miss_cycles.

## Test plan
- Reset with RESET_VECTOR=32'h100, icache_miss=0, decode_ready=1 -> icache_address 0x100, 0x104, 0x108 on consecutive cycles; instr_pc follows one cycle later; instr_valid=1 from first edge after reset release.
- icache_miss=1 for 3 cycles at pc=0x108 -> pc holds 0x108, miss_stall=1 for 3 cycles, miss_events=1, miss_cycles=3, then instr_pc=0x108 captured.
- decode_ready=0 for 2 cycles with slot full -> instr, instr_pc, pc unchanged; resume with no skipped or duplicated pc.
- redirect_valid with target 0x200 during MISS and decode_ready=1 -> instr_valid=0 next cycle, state RUN, icache_address 0x200, first instr_pc=0x200 two edges later.
- redirect_target=0x303 -> pc=0x300, fetch_misaligned pulses exactly one cycle.
- CNT_WIDTH=4, hold miss 20 cycles -> miss_cycles saturates at 15; reset_n pulsed low mid-miss -> all outputs at reset values immediately.
